psum_requant_wb: RTL and testbench

Downstream writeback stage for the N×N systolic array. During the array's drain phase it takes one N-lane vector of 24-bit partial sums per beat. Each lane is requantized to signed int8 using a per-tile multiplier and rounding right-shift, then saturated. The packed N×8-bit result is written to the output SRAM through an active-low write port. A 4-state FSM tracks tile boundaries, pulses a done flag once the pipeline has drained, and keeps saturation statistics.

---
 rtl/psum_requant_wb.sv | 228 ++++++++++++++++++++++
 tb/tb_psum_requant_wb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_requant_wb.sv
// Writeback stage for the systolic array: requantizes N 24-bit partial sums to int8 and writes them to SRAM.
// Optional ReLU clamp is built only when REQUANT_RELU_EN is defined.
module psum_requant_wb #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*24-1:0]   psum_in,
  input  logic [12:0]       in_waddr,
  input  logic              in_wen_n,
  input  logic              in_last,
  input  logic [15:0]       cfg_mult,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_relu,
  input  logic [12:0]       cfg_base,
  output logic [12:0]       mem_waddr,
  output logic              mem_wen_n,
  output logic [N*8-1:0]    mem_wdata,
  output logic              wb_done,
  output logic              busy,
  output logic [15:0]       sat_cnt,
  output logic              overlap_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  r_flush_cnt;
  logic [15:0] r_cfg_mult;
  logic [4:0]  r_cfg_shift;
  logic [12:0] r_cfg_base;
  logic        r_overlap;
  logic [15:0] r_sat;

  logic        r_s1_valid;
  logic [12:0] r_s1_addr;
  logic [4:0]  r_s1_shift;
  logic        r_s2_valid;
  logic [12:0] r_s2_addr;
  logic [N*8-1:0] r_s2_data;
  logic        r_mem_wen_n;
  logic [12:0] r_mem_waddr;
  logic [N*8-1:0] r_mem_wdata;

  logic        w_beat;
  logic        w_idle;
  logic [15:0] w_mult;
  logic [4:0]  w_shift;
  logic [12:0] w_base;
  logic        w_relu_s2;
  logic signed [41:0] w_rnd;
  logic [N*8-1:0] w_y;
  logic [N-1:0]   w_clip;
  logic [15:0]    w_clip_cnt;
  logic [16:0]    w_sat_sum;

  assign w_beat  = ~in_wen_n;
  assign w_idle  = (r_state == ST_IDLE);
  // A beat arriving in IDLE uses the cfg being latched on that same cycle.
  assign w_mult  = w_idle ? cfg_mult  : r_cfg_mult;
  assign w_shift = w_idle ? cfg_shift : r_cfg_shift;
  assign w_base  = w_idle ? cfg_base  : r_cfg_base;

`ifdef REQUANT_RELU_EN
  logic r_cfg_relu;
  logic r_s1_relu;
  logic w_relu;

  assign w_relu    = w_idle ? cfg_relu : r_cfg_relu;
  assign w_relu_s2 = r_s1_relu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_relu <= 1'b0;
    end else if (w_idle && w_beat) begin
      r_cfg_relu <= cfg_relu;
    end
    r_s1_relu <= w_relu;
  end
`else
  logic w_unused_relu;
  assign w_unused_relu = cfg_relu;
  assign w_relu_s2     = 1'b0;
`endif

  // Round half toward +inf by adding half an LSB of the output before the shift.
  assign w_rnd = (r_s1_shift == 5'd0) ? 42'sd0 : (42'sd1 <<< (r_s1_shift - 5'd1));

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic signed [23:0] w_ps;
      logic signed [16:0] w_m;
      logic signed [40:0] r_p;
      logic signed [41:0] w_r;
      logic signed [41:0] w_q;
      logic [7:0]         w_lane_y;
      logic               w_lane_clip;

      assign w_ps = $signed(psum_in[gi*24 +: 24]);
      assign w_m  = $signed({1'b0, w_mult});

      always_ff @(posedge clk) begin
        r_p <= 41'(w_ps) * 41'(w_m);
      end

      assign w_r = 42'(r_p) + w_rnd;
      assign w_q = w_r >>> r_s1_shift;

      // A lane forced to zero by ReLU does not count as clipped.
      always_comb begin
        w_lane_y    = w_q[7:0];
        w_lane_clip = 1'b0;
        if (w_q > 42'sd127) begin
          w_lane_y    = 8'h7F;
          w_lane_clip = 1'b1;
        end else if (w_relu_s2 && (w_q < 42'sd0)) begin
          w_lane_y    = 8'h00;
        end else if (w_q < -42'sd128) begin
          w_lane_y    = 8'h80;
          w_lane_clip = 1'b1;
        end
      end

      assign w_y[gi*8 +: 8] = w_lane_y;
      assign w_clip[gi]     = w_lane_clip;
    end
  endgenerate

  always_comb begin
    w_clip_cnt = 16'd0;
    for (int i = 0; i < N; i++) begin
      w_clip_cnt = w_clip_cnt + 16'(w_clip[i]);
    end
  end

  assign w_sat_sum = {1'b0, r_sat} + {1'b0, w_clip_cnt};

  // FLUSH holds for a fixed three cycles: exactly the depth of the pipeline behind the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= 2'd0;
      r_cfg_mult  <= 16'd0;
      r_cfg_shift <= 5'd0;
      r_cfg_base  <= 13'd0;
      r_overlap   <= 1'b0;
      r_sat       <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_beat) begin
            r_cfg_mult  <= cfg_mult;
            r_cfg_shift <= cfg_shift;
            r_cfg_base  <= cfg_base;
            r_flush_cnt <= 2'd0;
            r_state     <= in_last ? ST_FLUSH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_beat && in_last) begin
            r_flush_cnt <= 2'd0;
            r_state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_beat) begin
            r_overlap <= 1'b1;
          end
          if (r_flush_cnt == 2'd2) begin
            r_state <= ST_DONE;
          end else begin
            r_flush_cnt <= r_flush_cnt + 2'd1;
          end
        end
        default: begin
          if (w_beat) begin
            r_overlap <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
      endcase

      if (w_idle && w_beat) begin
        r_sat <= 16'd0;
      end else if (r_s1_valid) begin
        r_sat <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_mem_wen_n <= 1'b1;
      r_mem_waddr <= 13'd0;
      r_mem_wdata <= '0;
    end else begin
      r_s1_valid  <= w_beat;
      r_s2_valid  <= r_s1_valid;
      r_mem_wen_n <= ~r_s2_valid;
      if (r_s2_valid) begin
        r_mem_waddr <= r_s2_addr;
        r_mem_wdata <= r_s2_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_s1_addr  <= w_base + in_waddr;
    r_s1_shift <= w_shift;
    r_s2_addr  <= r_s1_addr;
    r_s2_data  <= w_y;
  end

  assign mem_waddr   = r_mem_waddr;
  assign mem_wen_n   = r_mem_wen_n;
  assign mem_wdata   = r_mem_wdata;
  assign wb_done     = (r_state == ST_DONE);
  assign busy        = (r_state != ST_IDLE);
  assign sat_cnt     = r_sat;
  assign overlap_err = r_overlap;

endmodule

// File: tb/tb_psum_requant_wb.sv
// Self-checking bench for psum_requant_wb: constant vector table, hand sequences, random tiles vs a reference model.
// Expectations follow REQUANT_RELU_EN the same way the design does.
module tb_psum_requant_wb;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*24-1:0]   psum_in;
  logic [12:0]       in_waddr;
  logic              in_wen_n;
  logic              in_last;
  logic [15:0]       cfg_mult;
  logic [4:0]        cfg_shift;
  logic              cfg_relu;
  logic [12:0]       cfg_base;
  logic [12:0]       mem_waddr;
  logic              mem_wen_n;
  logic [N*8-1:0]    mem_wdata;
  logic              wb_done;
  logic              busy;
  logic [15:0]       sat_cnt;
  logic              overlap_err;

  psum_requant_wb #(.N(N)) dut (
    .clk(clk), .rst(rst), .psum_in(psum_in), .in_waddr(in_waddr), .in_wen_n(in_wen_n),
    .in_last(in_last), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .cfg_base(cfg_base), .mem_waddr(mem_waddr), .mem_wen_n(mem_wen_n), .mem_wdata(mem_wdata),
    .wb_done(wb_done), .busy(busy), .sat_cnt(sat_cnt), .overlap_err(overlap_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          due;
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [3:0][23:0] ps;
    int               mult;
    int               shift;
    bit               relu;
    logic [31:0]      y;
    int               sat;
  } vec_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   done_pulses = 0;

  // Reference model state: tile in progress, edge of its last beat, tile cfg, clip total, sticky overlap.
  bit          m_in_tile = 1'b0;
  int          m_last = -100;
  int          m_sat = 0;
  bit          m_ovl = 1'b0;
  int          t_mult = 0;
  int          t_shift = 0;
  bit          t_relu = 1'b0;
  logic [12:0] t_base = 13'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    #1;
    if (wb_done) done_pulses++;
    if (!mem_wen_n) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0].due != edge_cnt) begin
        errors++;
        $display("FAIL unexpected_write edge=%0d addr=%h data=%h required=no write", edge_cnt, mem_waddr, mem_wdata);
      end else begin
        if (mem_waddr !== exp_q[0].addr || mem_wdata !== exp_q[0].data) begin
          errors++;
          $display("FAIL write edge=%0d actual addr=%h data=%h required addr=%h data=%h",
                   edge_cnt, mem_waddr, mem_wdata, exp_q[0].addr, exp_q[0].data);
        end else begin
          $display("write edge=%0d addr=%h data=%h ok", edge_cnt, mem_waddr, mem_wdata);
        end
        exp_q.delete(0);
      end
    end else if (exp_q.size() != 0 && exp_q[0].due == edge_cnt) begin
      checks++;
      errors++;
      $display("FAIL missing_write edge=%0d actual=no write required addr=%h data=%h",
               edge_cnt, exp_q[0].addr, exp_q[0].data);
      exp_q.delete(0);
    end
  end

  function automatic void ref_lane(input int psum, input int mult, input int shift, input bit relu,
                                   output int y, output bit clip);
    longint v;
    bit     relu_on;
`ifdef REQUANT_RELU_EN
    relu_on = relu;
`else
    relu_on = 1'b0;
`endif
    v = longint'(psum) * longint'(mult);
    if (shift > 0) v = v + (longint'(1) <<< (shift - 1));
    v = v >>> shift;
    clip = 1'b0;
    if (v > 127) begin
      y = 127; clip = 1'b1;
    end else if (relu_on && v < 0) begin
      y = 0;
    end else if (v < -128) begin
      y = -128; clip = 1'b1;
    end else begin
      y = int'(v);
    end
  endfunction

  function automatic vec_t mk(input int p0, input int p1, input int p2, input int p3,
                              input int mult, input int shift, input bit relu,
                              input int y0, input int y1, input int y2, input int y3, input int sat);
    vec_t v;
    int   pv[4];
    int   yv[4];
    pv = '{p0, p1, p2, p3};
    yv = '{y0, y1, y2, y3};
    for (int i = 0; i < 4; i++) begin
      int a;
      int b;
      a = pv[i];
      b = yv[i];
      v.ps[i]        = a[23:0];
      v.y[i*8 +: 8]  = b[7:0];
    end
    v.mult = mult; v.shift = shift; v.relu = relu; v.sat = sat;
    return v;
  endfunction

  // Drives one beat for the next clock edge and records the write it must produce.
  task automatic drive_beat(input logic [3:0][23:0] ps, input logic [12:0] wa, input bit last,
                            input int mult, input int shift, input bit relu, input logic [12:0] base,
                            input bit ovr, input logic [31:0] ovr_data);
    int          p;
    int          y;
    bit          c;
    logic [31:0] d;
    wr_t         w;
    p = edge_cnt + 1;
    if (m_in_tile) begin
      if (last) begin
        m_in_tile = 1'b0;
        m_last    = p;
      end
    end else if (p <= m_last + 4) begin
      m_ovl = 1'b1;
    end else begin
      t_mult = mult; t_shift = shift; t_relu = relu; t_base = base;
      m_sat = 0;
      if (last) m_last = p;
      else m_in_tile = 1'b1;
    end
    d = '0;
    for (int i = 0; i < N; i++) begin
      ref_lane(int'($signed(ps[i])), t_mult, t_shift, t_relu, y, c);
      d[i*8 +: 8] = y[7:0];
      if (c && m_sat < 65535) m_sat++;
    end
    w.due  = p + 2;
    w.addr = t_base + wa;
    w.data = ovr ? ovr_data : d;
    exp_q.push_back(w);
    psum_in   = ps;
    in_waddr  = wa;
    in_last   = last;
    cfg_mult  = mult[15:0];
    cfg_shift = shift[4:0];
    cfg_relu  = relu;
    cfg_base  = base;
    in_wen_n  = 1'b0;
    @(negedge clk);
    in_wen_n  = 1'b1;
    in_last   = 1'b0;
  endtask

  function automatic logic [3:0][23:0] rand_ps();
    logic [3:0][23:0] ps;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 1) == 1) ps[i] = 24'($urandom);
      else ps[i] = 24'($urandom_range(0, 4000)) - 24'd2000;
    end
    return ps;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wen_n"},   32'(mem_wen_n),   32'd1);
    chk({tag, "_waddr"},   32'(mem_waddr),   32'd0);
    chk({tag, "_wdata"},   32'(mem_wdata),   32'd0);
    chk({tag, "_wb_done"}, 32'(wb_done),     32'd0);
    chk({tag, "_busy"},    32'(busy),        32'd0);
    chk({tag, "_sat"},     32'(sat_cnt),     32'd0);
    chk({tag, "_overlap"}, 32'(overlap_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t             tbl[6];
    logic [3:0][23:0] ps;
    int               d0;
    int               len;
    int               mult;
    int               shift;
    bit               relu;
    logic [12:0]      base;

    tbl[0] = mk(1000, -1000, 0, 7,            1, 3, 1'b0, 125, -125, 0, 1, 0);
    tbl[1] = mk(5000, -5000, 8, -8,           1, 4, 1'b0, 127, -128, 1, 0, 2);
    tbl[2] = mk(-50, 50, 42, -42,             3, 0, 1'b0, -128, 127, 126, -126, 2);
`ifdef REQUANT_RELU_EN
    tbl[3] = mk(-8, 100, -200, 300,           1, 0, 1'b1, 0, 100, 0, 127, 1);
`else
    tbl[3] = mk(-8, 100, -200, 300,           1, 0, 1'b1, -8, 100, -128, 127, 2);
`endif
    tbl[4] = mk(8388607, -8388608, 1, -1, 65535, 31, 1'b0, 127, -128, 0, 0, 2);
    tbl[5] = mk(1, -1, 3, -3,                 1, 1, 1'b0, 1, 0, 2, -1, 0);

    rst = 1'b1; psum_in = '0; in_waddr = '0; in_wen_n = 1'b1; in_last = 1'b0;
    cfg_mult = '0; cfg_shift = '0; cfg_relu = 1'b0; cfg_base = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Constant vectors, each as a single-beat tile.
    for (int i = 0; i < 6; i++) begin
      drive_beat(tbl[i].ps, 13'(i * 5), 1'b1, tbl[i].mult, tbl[i].shift, tbl[i].relu,
                 13'h0100, 1'b1, tbl[i].y);
      repeat (5) @(negedge clk);
      chk($sformatf("tbl%0d_sat", i), 32'(sat_cnt), 32'(tbl[i].sat));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'd0);
    end

    // 8-beat tile whose addresses wrap past 0x1FFF.
    d0 = done_pulses;
    for (int b = 0; b < 8; b++) begin
      drive_beat(rand_ps(), 13'(b), (b == 7), 1, 0, 1'b0, 13'h1FFC, 1'b0, '0);
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("wrap_wb_done_k%0d", k), 32'(wb_done), 32'(k == 3));
      chk($sformatf("wrap_busy_k%0d", k), 32'(busy), 32'(k < 4));
      @(negedge clk);
    end
    chk("wrap_sat", 32'(sat_cnt), 32'(m_sat));
    chk("wrap_done_pulses", 32'(done_pulses - d0), 32'd1);
    chk("wrap_overlap", 32'(overlap_err), 32'd0);

    // Beat injected two cycles after the last beat of a tile.
    d0 = done_pulses;
    drive_beat(rand_ps(), 13'd10, 1'b0, 7, 2, 1'b0, 13'h0200, 1'b0, '0);
    drive_beat(rand_ps(), 13'd11, 1'b1, 9, 5, 1'b0, 13'h0300, 1'b0, '0);
    @(negedge clk);
    drive_beat(rand_ps(), 13'd12, 1'b0, 200, 9, 1'b0, 13'h0400, 1'b0, '0);
    repeat (8) @(negedge clk);
    chk("ovl_overlap_err", 32'(overlap_err), 32'(m_ovl));
    chk("ovl_done_pulses", 32'(done_pulses - d0), 32'd1);
    chk("ovl_busy", 32'(busy), 32'd0);

    // Random tiles with gaps and cfg inputs that must be ignored mid-tile.
    for (int t = 0; t < 25; t++) begin
      d0  = done_pulses;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        mult  = $urandom_range(0, 65535);
        shift = $urandom_range(0, 20);
        relu  = 1'($urandom_range(0, 1));
        base  = 13'($urandom);
        drive_beat(rand_ps(), 13'($urandom), (b == len - 1), mult, shift, relu, base, 1'b0, '0);
        if (b != len - 1) begin
          repeat ($urandom_range(0, 2)) begin
            cfg_mult = 16'($urandom); cfg_shift = 5'($urandom); cfg_base = 13'($urandom);
            @(negedge clk);
          end
        end
      end
      repeat (6) @(negedge clk);
      chk($sformatf("rnd%0d_sat", t), 32'(sat_cnt), 32'(m_sat));
      chk($sformatf("rnd%0d_done", t), 32'(done_pulses - d0), 32'd1);
    end
    chk("rnd_overlap_sticky", 32'(overlap_err), 32'(m_ovl));

    // Reset with two beats in flight.
    drive_beat(rand_ps(), 13'd1, 1'b0, 300, 2, 1'b0, 13'h0055, 1'b0, '0);
    drive_beat(rand_ps(), 13'd2, 1'b0, 300, 2, 1'b0, 13'h0055, 1'b0, '0);
    rst = 1'b1;
    exp_q.delete();
    m_in_tile = 1'b0; m_last = -100; m_sat = 0; m_ovl = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("midrst");
    @(negedge clk);
    chk("midrst_next_wen_n", 32'(mem_wen_n), 32'd1);

    d0 = done_pulses;
    drive_beat(rand_ps(), 13'd4, 1'b1, 1000, 6, 1'b0, 13'h0777, 1'b0, '0);
    repeat (6) @(negedge clk);
    chk("post_rst_sat", 32'(sat_cnt), 32'(m_sat));
    chk("post_rst_done", 32'(done_pulses - d0), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
